// File: rtl/lr_position_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lr_position_ctrl
//  Purpose  : Cursor position controller for an LED bar, driven by debounced
//             left/right pulses; one-hot LED drive, wall bump and move count.
//  Revision : 1.0  initial release
// ============================================================================
module lr_position_ctrl #(
    parameter int N_POS       = 16,
    parameter int START_POS   = 0,
    parameter int WRAP        = 0,
    parameter int BUMP_CYCLES = 25_000_000,
    localparam int POS_W      = $clog2(N_POS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             left_pulse,
    input  logic             right_pulse,
    output logic [POS_W-1:0] pos,
    output logic [N_POS-1:0] led,
    output logic             at_left,
    output logic             at_right,
    output logic             bump,
    output logic [15:0]      move_count
);

    localparam int               CNT_W    = (BUMP_CYCLES > 1) ? $clog2(BUMP_CYCLES) : 1;
    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(N_POS - 1);
    localparam logic [POS_W-1:0] POS_RST  = POS_W'(START_POS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUMP_CYCLES - 1);
    localparam logic [N_POS-1:0] LED_RST  = N_POS'(1) << START_POS;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUMP = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [N_POS-1:0]   led_q, led_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        move_count_q, move_count_d;
    logic               bump_q, bump_d;

    logic               go_left;
    logic               go_right;
    logic               hit;
    logic               move;

    assign at_left  = (pos_q == POS_MAX);
    assign at_right = (pos_q == '0);

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        led_d        = led_q;
        cnt_d        = cnt_q;
        move_count_d = move_count_q;

        // Simultaneous pulses cancel: neither a move nor a wall hit.
        go_left  = left_pulse & ~right_pulse;
        go_right = right_pulse & ~left_pulse;
        hit      = ((go_left & at_left) | (go_right & at_right)) & (WRAP == 0);
        move     = (go_left | go_right) & ~hit;

        if (hit) begin
            state_d = S_BUMP;
            cnt_d   = CNT_LOAD;
        end else if (move) begin
            if (go_left) begin
                pos_d = at_left ? '0 : pos_q + POS_W'(1);
            end else begin
                pos_d = at_right ? POS_MAX : pos_q - POS_W'(1);
            end
            move_count_d = move_count_q + 16'd1;
            state_d      = S_IDLE;
            cnt_d        = '0;
        end else if (state_q == S_BUMP) begin
            if (cnt_q == '0) begin
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        bump_d = (state_d == S_BUMP);

        for (int i = 0; i < N_POS; i++) begin
            led_d[i] = (pos_d == POS_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pos_q        <= POS_RST;
            led_q        <= LED_RST;
            cnt_q        <= '0;
            move_count_q <= '0;
            bump_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            led_q        <= led_d;
            cnt_q        <= cnt_d;
            move_count_q <= move_count_d;
            bump_q       <= bump_d;
        end
    end

    assign pos        = pos_q;
    assign led        = led_q;
    assign bump       = bump_q;
    assign move_count = move_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lr_position_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lr_position_ctrl
//  Purpose  : Bench for lr_position_ctrl: a saturating instance (START_POS=3)
//             and a wrapping instance (START_POS=0) against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lr_position_ctrl;

    localparam int N  = 16;
    localparam int BC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  lp, rp;

    logic [3:0]  pos_a, pos_b;
    logic [15:0] led_a, led_b, mc_a, mc_b;
    logic        atl_a, atl_b, atr_a, atr_b, bump_a, bump_b;

    int checks = 0;
    int errors = 0;

    // Model state per instance: position, move count, remaining bump cycles.
    int m_pos[2];
    int m_mc[2];
    int m_rem[2];
    int delta, tgt;
    int hi, guard;

    always #5 clk = ~clk;

    lr_position_ctrl #(.N_POS(N), .START_POS(3), .WRAP(0), .BUMP_CYCLES(BC)) dut_a (
        .clk(clk), .rst(rst), .left_pulse(lp[0]), .right_pulse(rp[0]),
        .pos(pos_a), .led(led_a), .at_left(atl_a), .at_right(atr_a),
        .bump(bump_a), .move_count(mc_a)
    );

    lr_position_ctrl #(.N_POS(N), .START_POS(0), .WRAP(1), .BUMP_CYCLES(BC)) dut_b (
        .clk(clk), .rst(rst), .left_pulse(lp[1]), .right_pulse(rp[1]),
        .pos(pos_b), .led(led_b), .at_left(atl_b), .at_right(atr_b),
        .bump(bump_b), .move_count(mc_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int start_of(input int k);
        return (k == 0) ? 3 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pos[k] = start_of(k);
                m_mc[k]  = 0;
                m_rem[k] = 0;
            end else begin
                delta = int'(lp[k]) - int'(rp[k]);
                if (delta == 0) begin
                    m_rem[k] = (m_rem[k] > 0) ? m_rem[k] - 1 : 0;
                end else begin
                    tgt = m_pos[k] + delta;
                    if (tgt >= 0 && tgt < N) begin
                        m_pos[k] = tgt;
                        m_mc[k]  = (m_mc[k] + 1) % 65536;
                        m_rem[k] = 0;
                    end else if (k == 1) begin
                        m_pos[k] = (tgt + N) % N;
                        m_mc[k]  = (m_mc[k] + 1) % 65536;
                        m_rem[k] = 0;
                    end else begin
                        m_rem[k] = BC;
                    end
                end
            end
        end
    end

    task automatic cmp(input int k, input logic [3:0] p, input logic [15:0] l,
                       input logic al, input logic ar, input logic b, input logic [15:0] mc);
        chk($sformatf("pos[%0d]", k),  64'(p),  64'(m_pos[k]));
        chk($sformatf("led[%0d]", k),  64'(l),  64'd1 << m_pos[k]);
        chk($sformatf("at_left[%0d]", k),  64'(al), 64'(m_pos[k] == N - 1));
        chk($sformatf("at_right[%0d]", k), 64'(ar), 64'(m_pos[k] == 0));
        chk($sformatf("bump[%0d]", k), 64'(b),  64'(m_rem[k] > 0));
        chk($sformatf("move_count[%0d]", k), 64'(mc), 64'(m_mc[k]));
    endtask

    always @(posedge clk) begin
        #1;
        cmp(0, pos_a, led_a, atl_a, atr_a, bump_a, mc_a);
        cmp(1, pos_b, led_b, atl_b, atr_b, bump_b, mc_b);
    end

    task automatic cyc(input bit la, input bit ra, input bit lb, input bit rb);
        lp = {lb, la};
        rp = {rb, ra};
        @(negedge clk);
        lp = '0;
        rp = '0;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst = 1'b1;
        lp  = '0;
        rp  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_pos_a", 64'(pos_a), 64'd3);
        chk("rst_led_a", 64'(led_a), 64'h0008);
        chk("rst_mc_a",  64'(mc_a),  64'd0);
        chk("rst_pos_b", 64'(pos_b), 64'd0);

        // Stepping on the wrapping instance
        repeat (5) cyc(0, 0, 1, 0);
        chk("t2_pos5", 64'(pos_b), 64'd5);
        chk("t2_led5", 64'(led_b), 64'h0020);
        chk("t2_mc5",  64'(mc_b),  64'd5);
        repeat (2) cyc(0, 0, 0, 1);
        chk("t2_pos3", 64'(pos_b), 64'd3);
        chk("t2_mc7",  64'(mc_b),  64'd7);

        // Saturating instance walks to the right wall
        repeat (3) cyc(0, 1, 0, 0);
        chk("t3_at_wall", 64'(atr_a), 64'd1);
        chk("t3_mc3",     64'(mc_a),  64'd3);

        hi    = 0;
        guard = 0;
        cyc(0, 1, 0, 0);
        while (bump_a && guard < 20) begin
            hi++;
            guard++;
            cyc(0, 0, 0, 0);
        end
        chk("t3_bump_width", 64'(hi), 64'd4);
        chk("t3_pos_held",   64'(pos_a), 64'd0);
        chk("t3_mc_held",    64'(mc_a),  64'd3);

        // Reload while bumping extends bump to BC cycles from the reload
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        chk("t3_reload_hi", 64'(bump_a), 64'd1);
        cyc(0, 0, 0, 0);
        chk("t3_reload_lo", 64'(bump_a), 64'd0);
        chk("t3_reload_mc", 64'(mc_a),   64'd3);

        // Escape from bump
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t4_bumping", 64'(bump_a), 64'd1);
        cyc(1, 0, 0, 0);
        chk("t4_pos",  64'(pos_a),  64'd1);
        chk("t4_bump", 64'(bump_a), 64'd0);
        chk("t4_mc",   64'(mc_a),   64'd4);

        // Simultaneous pulses during bump: countdown continues
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("t6b_pos",  64'(pos_a),  64'd0);
        chk("t6b_mc",   64'(mc_a),   64'd5);
        chk("t6b_bump", 64'(bump_a), 64'd1);
        repeat (2) cyc(0, 0, 0, 0);
        chk("t6b_bump_hi", 64'(bump_a), 64'd1);
        cyc(0, 0, 0, 0);
        chk("t6b_bump_lo", 64'(bump_a), 64'd0);

        // Simultaneous pulses in idle
        cyc(0, 0, 1, 1);
        chk("t6i_pos", 64'(pos_b), 64'd3);
        chk("t6i_mc",  64'(mc_b),  64'd7);

        // Wrap on both ends
        repeat (12) cyc(0, 0, 1, 0);
        chk("t5_pos15",  64'(pos_b), 64'd15);
        chk("t5_atleft", 64'(atl_b), 64'd1);
        cyc(0, 0, 1, 0);
        chk("t5_pos0",  64'(pos_b),  64'd0);
        chk("t5_led",   64'(led_b),  64'h0001);
        chk("t5_mc",    64'(mc_b),   64'd20);
        chk("t5_bump",  64'(bump_b), 64'd0);
        cyc(0, 0, 0, 1);
        chk("t5_rwrap", 64'(pos_b), 64'd15);
        cyc(0, 0, 1, 0);
        chk("t5_mc22",  64'(mc_b),  64'd22);

        // Held level counts every cycle; drive move_count to its wrap point
        repeat (65513) cyc(0, 0, 1, 0);
        chk("t6_mc_max",  64'(mc_b),  64'hFFFF);
        chk("t6_pos_max", 64'(pos_b), 64'd9);
        cyc(0, 0, 1, 0);
        chk("t6_mc_wrap", 64'(mc_b),  64'd0);
        chk("t6_pos_wr",  64'(pos_b), 64'd10);

        // Asynchronous reset in the middle of a bump
        cyc(0, 1, 0, 0);
        chk("t1_bumping", 64'(bump_a), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("t1_pos",  64'(pos_a),  64'd3);
        chk("t1_led",  64'(led_a),  64'h0008);
        chk("t1_bump", 64'(bump_a), 64'd0);
        chk("t1_mc",   64'(mc_a),   64'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        repeat (2) cyc(0, 0, 0, 0);
        chk("t1_after_pos",  64'(pos_a),  64'd3);
        chk("t1_after_bump", 64'(bump_a), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
